// File: rtl/axis_demux_pkg.sv
// Shared types and constants for the packet-aware 1:2 AXI-Stream demultiplexer.
package axis_demux_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } demux_state_t;

    localparam logic ROUTE_M1 = 1'b1;
    localparam logic ROUTE_M2 = 1'b0;

endpackage

// File: rtl/axis_demux_1_2_slice.sv
// Two-entry AXI-Stream register slice: the main register drives the output and
// the skid register catches one beat when the downstream ready drops.
module axis_reg_slice #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_tdata,
    input  logic          in_tvalid,
    input  logic          in_tlast,
    output logic          in_tready,
    output logic [DW-1:0] out_tdata,
    output logic          out_tvalid,
    output logic          out_tlast,
    input  logic          out_tready
);

    logic [DW-1:0] main_data_q, main_data_d;
    logic          main_last_q, main_last_d;
    logic          main_valid_q, main_valid_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic          skid_last_q, skid_last_d;
    logic          skid_valid_q, skid_valid_d;
    logic          push;

    always_comb begin
        in_tready    = ~skid_valid_q;
        push         = in_tvalid & ~skid_valid_q;
        main_data_d  = main_data_q;
        main_last_d  = main_last_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        skid_valid_d = skid_valid_q;
        if (~main_valid_q | out_tready) begin
            // Main register is free this cycle; drain the skid first to keep order.
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                main_last_d  = skid_last_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = push;
                if (push) begin
                    main_data_d = in_tdata;
                    main_last_d = in_tlast;
                end
            end
        end else if (push) begin
            skid_data_d  = in_tdata;
            skid_last_d  = in_tlast;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q  <= '0;
            main_last_q  <= 1'b0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_last_q  <= main_last_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_tdata  = main_data_q;
    assign out_tvalid = main_valid_q;
    assign out_tlast  = main_last_q;

endmodule

// File: rtl/axis_demux_1_2.sv
// Packet-aware 1:2 AXI-Stream demux; whole packets go to m1 (sel=1) or m2 (sel=0).
// Optional per-output packet counters are enabled with AXIS_DEMUX_PKT_CNT_EN.
//
// state | meaning
// IDLE  | between packets; live sel routes the current beat
// ROUTE | mid-packet; latched route is used until tlast is accepted
module axis_demux_1_2
    import axis_demux_pkg::*;
#(
    parameter int DW = 8
`ifdef AXIS_DEMUX_PKT_CNT_EN
    , parameter int CW = 16
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic [DW-1:0] m1_tdata,
    output logic          m1_tvalid,
    output logic          m1_tlast,
    input  logic          m1_tready,
    output logic [DW-1:0] m2_tdata,
    output logic          m2_tvalid,
    output logic          m2_tlast,
    input  logic          m2_tready
`ifdef AXIS_DEMUX_PKT_CNT_EN
    ,
    output logic [CW-1:0] m1_pkt_cnt,
    output logic [CW-1:0] m2_pkt_cnt
`endif
);

    demux_state_t state_q, state_d;
    logic         route_q, route_d;
    logic         route_sel;
    logic         accept;
    logic         m1_push, m2_push;
    logic         m1_in_ready, m2_in_ready;

    always_comb begin
        route_sel = (state_q == IDLE) ? sel : route_q;
        s_tready  = ~rst & ((route_sel == ROUTE_M1) ? m1_in_ready : m2_in_ready);
        accept    = s_tvalid & s_tready;
        m1_push   = accept & (route_sel == ROUTE_M1);
        m2_push   = accept & (route_sel == ROUTE_M2);
        state_d   = state_q;
        route_d   = route_q;
        case (state_q)
            IDLE: begin
                if (accept & ~s_tlast) begin
                    state_d = ROUTE;
                    route_d = sel;
                end
            end
            ROUTE: begin
                if (accept & s_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            route_q <= ROUTE_M2;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    axis_reg_slice #(.DW(DW)) u_slice_m1 (
        .clk        (clk),
        .rst        (rst),
        .in_tdata   (s_tdata),
        .in_tvalid  (m1_push),
        .in_tlast   (s_tlast),
        .in_tready  (m1_in_ready),
        .out_tdata  (m1_tdata),
        .out_tvalid (m1_tvalid),
        .out_tlast  (m1_tlast),
        .out_tready (m1_tready)
    );

    axis_reg_slice #(.DW(DW)) u_slice_m2 (
        .clk        (clk),
        .rst        (rst),
        .in_tdata   (s_tdata),
        .in_tvalid  (m2_push),
        .in_tlast   (s_tlast),
        .in_tready  (m2_in_ready),
        .out_tdata  (m2_tdata),
        .out_tvalid (m2_tvalid),
        .out_tlast  (m2_tlast),
        .out_tready (m2_tready)
    );

`ifdef AXIS_DEMUX_PKT_CNT_EN
    logic [CW-1:0] m1_cnt_q, m1_cnt_d;
    logic [CW-1:0] m2_cnt_q, m2_cnt_d;

    always_comb begin
        m1_cnt_d = m1_cnt_q + CW'(m1_tvalid & m1_tready & m1_tlast);
        m2_cnt_d = m2_cnt_q + CW'(m2_tvalid & m2_tready & m2_tlast);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m1_cnt_q <= '0;
            m2_cnt_q <= '0;
        end else begin
            m1_cnt_q <= m1_cnt_d;
            m2_cnt_q <= m2_cnt_d;
        end
    end

    assign m1_pkt_cnt = m1_cnt_q;
    assign m2_pkt_cnt = m2_cnt_q;
`endif

endmodule

// File: tb/tb_axis_demux_1_2.sv
// Directed self-checking bench for axis_demux_1_2; counter checks are built
// only when AXIS_DEMUX_PKT_CNT_EN is defined.
module tb_axis_demux_1_2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tready;
    logic [7:0] m1_tdata;
    logic       m1_tvalid;
    logic       m1_tlast;
    logic       m1_tready;
    logic [7:0] m2_tdata;
    logic       m2_tvalid;
    logic       m2_tlast;
    logic       m2_tready;
`ifdef AXIS_DEMUX_PKT_CNT_EN
    logic [15:0] m1_pkt_cnt;
    logic [15:0] m2_pkt_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axis_demux_1_2 #(.DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m1_tdata   (m1_tdata),
        .m1_tvalid  (m1_tvalid),
        .m1_tlast   (m1_tlast),
        .m1_tready  (m1_tready),
        .m2_tdata   (m2_tdata),
        .m2_tvalid  (m2_tvalid),
        .m2_tlast   (m2_tlast),
        .m2_tready  (m2_tready)
`ifdef AXIS_DEMUX_PKT_CNT_EN
        ,
        .m1_pkt_cnt (m1_pkt_cnt),
        .m2_pkt_cnt (m2_pkt_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a rising edge, then return at the falling edge for checks.
    task automatic cyc(input logic r, input logic s, input logic v, input logic [7:0] d,
                       input logic l, input logic r1, input logic r2);
        @(posedge clk);
        #1;
        rst = r; sel = s; s_tvalid = v; s_tdata = d; s_tlast = l;
        m1_tready = r1; m2_tready = r2;
        @(negedge clk);
    endtask

    task automatic chk_m1(input string tag, input logic v, input logic [7:0] d, input logic l);
        chk({tag, "_m1v"}, 32'(m1_tvalid), 32'(v));
        if (v) begin
            chk({tag, "_m1d"}, 32'(m1_tdata), 32'(d));
            chk({tag, "_m1l"}, 32'(m1_tlast), 32'(l));
        end
    endtask

    task automatic chk_m2(input string tag, input logic v, input logic [7:0] d, input logic l);
        chk({tag, "_m2v"}, 32'(m2_tvalid), 32'(v));
        if (v) begin
            chk({tag, "_m2d"}, 32'(m2_tdata), 32'(d));
            chk({tag, "_m2l"}, 32'(m2_tlast), 32'(l));
        end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b1; s_tvalid = 1'b1; s_tdata = 8'h11; s_tlast = 1'b1;
        m1_tready = 1'b1; m2_tready = 1'b1;

        // Reset held 3 cycles with valid input
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 1, 8'h11, 1, 1, 1);
            chk("rst_srdy", 32'(s_tready), 32'h0);
            chk_m1("rst", 0, 8'h00, 0);
            chk_m2("rst", 0, 8'h00, 0);
            chk("rst_m1d", 32'(m1_tdata), 32'h0);
            chk("rst_m2l", 32'(m2_tlast), 32'h0);
        end
        cyc(0, 1, 1, 8'h11, 1, 1, 1);
        chk("rel_srdy", 32'(s_tready), 32'h1);
        cyc(0, 1, 0, 8'h00, 0, 1, 1);
        chk_m1("rel", 1, 8'h11, 1);
        chk_m2("rel", 0, 8'h00, 0);

        // Mid-packet sel change stays on m1
        cyc(0, 1, 1, 8'hA0, 0, 1, 1);
        chk("sw0_srdy", 32'(s_tready), 32'h1);
        cyc(0, 1, 1, 8'hA1, 0, 1, 1);
        chk_m1("sw1", 1, 8'hA0, 0);
        cyc(0, 0, 1, 8'hA2, 0, 1, 1);
        chk_m1("sw2", 1, 8'hA1, 0);
        chk("sw2_srdy", 32'(s_tready), 32'h1);
        chk_m2("sw2", 0, 8'h00, 0);
        cyc(0, 0, 1, 8'hA3, 1, 1, 1);
        chk_m1("sw3", 1, 8'hA2, 0);
        chk_m2("sw3", 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 0, 1, 1);
        chk_m1("sw4", 1, 8'hA3, 1);
        chk_m2("sw4", 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 0, 1, 1);
        chk_m1("sw5", 0, 8'h00, 0);

        // Back-to-back: 1-beat to m2 then 3-beat to m1, no input bubble
        cyc(0, 0, 1, 8'h55, 1, 1, 1);
        chk("bb0_srdy", 32'(s_tready), 32'h1);
        cyc(0, 1, 1, 8'h60, 0, 1, 1);
        chk("bb1_srdy", 32'(s_tready), 32'h1);
        chk_m2("bb1", 1, 8'h55, 1);
        chk_m1("bb1", 0, 8'h00, 0);
        cyc(0, 0, 1, 8'h61, 0, 1, 1);
        chk("bb2_srdy", 32'(s_tready), 32'h1);
        chk_m1("bb2", 1, 8'h60, 0);
        chk_m2("bb2", 0, 8'h00, 0);
        cyc(0, 0, 1, 8'h62, 1, 1, 1);
        chk("bb3_srdy", 32'(s_tready), 32'h1);
        chk_m1("bb3", 1, 8'h61, 0);
        cyc(0, 0, 0, 8'h00, 0, 1, 1);
        chk_m1("bb4", 1, 8'h62, 1);
        chk_m2("bb4", 0, 8'h00, 0);

        // Backpressure on m1 for 5 cycles mid-packet
        cyc(0, 1, 1, 8'hB0, 0, 1, 1);
        chk("bp0_srdy", 32'(s_tready), 32'h1);
        cyc(0, 1, 1, 8'hB1, 0, 1, 1);
        chk_m1("bp1", 1, 8'hB0, 0);
        cyc(0, 1, 1, 8'hB2, 0, 0, 1);
        chk_m1("bp2", 1, 8'hB1, 0);
        chk("bp2_srdy", 32'(s_tready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 1, 8'hB3, 0, 0, 1);
            chk("bp_hold_srdy", 32'(s_tready), 32'h0);
            chk_m1("bp_hold", 1, 8'hB1, 0);
            chk_m2("bp_hold", 0, 8'h00, 0);
        end
        cyc(0, 1, 1, 8'hB3, 0, 1, 1);
        chk("bp7_srdy", 32'(s_tready), 32'h0);
        chk_m1("bp7", 1, 8'hB1, 0);
        cyc(0, 1, 1, 8'hB3, 0, 1, 1);
        chk("bp8_srdy", 32'(s_tready), 32'h1);
        chk_m1("bp8", 1, 8'hB2, 0);
        cyc(0, 1, 1, 8'hB4, 1, 1, 1);
        chk_m1("bp9", 1, 8'hB3, 0);
        cyc(0, 1, 0, 8'h00, 0, 1, 1);
        chk_m1("bp10", 1, 8'hB4, 1);
        cyc(0, 1, 0, 8'h00, 0, 1, 1);
        chk_m1("bp11", 0, 8'h00, 0);

        // Reset mid-packet with beats stuck in the m2 slice
        cyc(0, 0, 1, 8'hC0, 0, 1, 0);
        chk("rm0_srdy", 32'(s_tready), 32'h1);
        cyc(0, 0, 1, 8'hC1, 0, 1, 0);
        chk_m2("rm1", 1, 8'hC0, 0);
        chk("rm1_srdy", 32'(s_tready), 32'h1);
        cyc(1, 0, 1, 8'hC2, 0, 1, 0);
        chk("rm2_srdy", 32'(s_tready), 32'h0);
        cyc(0, 1, 1, 8'hD0, 1, 1, 1);
        chk_m2("rm3", 0, 8'h00, 0);
        chk_m1("rm3", 0, 8'h00, 0);
        chk("rm3_srdy", 32'(s_tready), 32'h1);
        cyc(0, 0, 0, 8'h00, 0, 1, 1);
        chk_m1("rm4", 1, 8'hD0, 1);
        chk_m2("rm4", 0, 8'h00, 0);

`ifdef AXIS_DEMUX_PKT_CNT_EN
        // Packet counters: 3 single-beat packets to m1, 2 to m2
        cyc(1, 0, 0, 8'h00, 0, 1, 1);
        cyc(0, 0, 0, 8'h00, 0, 1, 1);
        chk("cnt_rst_m1", 32'(m1_pkt_cnt), 32'h0);
        chk("cnt_rst_m2", 32'(m2_pkt_cnt), 32'h0);
        cyc(0, 1, 1, 8'hE0, 1, 1, 1);
        cyc(0, 0, 1, 8'hE1, 1, 1, 1);
        cyc(0, 1, 1, 8'hE2, 1, 1, 1);
        cyc(0, 0, 1, 8'hE3, 1, 1, 1);
        cyc(0, 1, 1, 8'hE4, 1, 1, 1);
        cyc(0, 0, 0, 8'h00, 0, 1, 1);
        cyc(0, 0, 0, 8'h00, 0, 1, 1);
        chk("cnt_m1", 32'(m1_pkt_cnt), 32'h3);
        chk("cnt_m2", 32'(m2_pkt_cnt), 32'h2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
